// File: rtl/spi_mul_master.sv
// SPI initiator: sends {opcode, A, B} (68 bits, MSB first) to the multiplier slave and reads back a 32-bit result.
// Optional abort support is compiled in with SPI_MUL_MASTER_ABORT_EN.
module spi_mul_master #(
   parameter int unsigned BIT_PERIOD   = 4,
   parameter int unsigned SETUP_CYCLES = 2
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic [3:0]  opcode_i,
   input  logic [31:0] operand_a_i,
   input  logic [31:0] operand_b_i,
`ifdef SPI_MUL_MASTER_ABORT_EN
   input  logic        abort_i,
   output logic        aborted_o,
`endif
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] result_o,
   output logic        sclk_o,
   output logic        mosi_o,
   output logic        nss_o,
   input  logic        miso_i
);

   localparam int unsigned FRAME_W = 68;
   localparam int unsigned RES_W   = 32;
   localparam int unsigned DIV_W   = 8;
   localparam int unsigned BIT_W   = 7;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_TX    = 3'd2,
      S_TURN  = 3'd3,
      S_RX    = 3'd4,
      S_DONE  = 3'd5
   } state_e;

   state_e               state_q, state_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [FRAME_W-1:0]   tx_q, tx_d;
   logic [RES_W-1:0]     rx_q, rx_d;
   logic [RES_W-1:0]     result_q, result_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 sclk_q, sclk_d;
   logic                 mosi_q, mosi_d;
   logic                 nss_q, nss_d;
   logic                 in_xfer_c;
   logic                 abort_c;
   logic                 bit_end_c;

   assign in_xfer_c = (state_q == S_SETUP) || (state_q == S_TX) ||
                      (state_q == S_TURN)  || (state_q == S_RX);
   assign bit_end_c = (div_q == DIV_W'(BIT_PERIOD - 1));

`ifdef SPI_MUL_MASTER_ABORT_EN
   logic aborted_q, aborted_d;
   assign abort_c   = abort_i && in_xfer_c;
   assign aborted_d = abort_c;
   assign aborted_o = aborted_q;
`else
   assign abort_c   = 1'b0;
`endif

   // State, datapath and output registers; result survives a reset that lands mid-frame.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         nss_q   <= 1'b1;
         if (in_xfer_c) result_q <= result_q;
         else           result_q <= '0;
`ifdef SPI_MUL_MASTER_ABORT_EN
         aborted_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         sclk_q   <= sclk_d;
         mosi_q   <= mosi_d;
         nss_q    <= nss_d;
`ifdef SPI_MUL_MASTER_ABORT_EN
         aborted_q <= aborted_d;
`endif
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               tx_d    = {opcode_i, operand_a_i, operand_b_i};
               div_d   = '0;
               bit_d   = '0;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            if (div_q == DIV_W'(SETUP_CYCLES - 1)) begin
               div_d   = '0;
               state_d = S_TX;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         S_TX: begin
            if (bit_end_c) begin
               div_d = '0;
               tx_d  = {tx_q[FRAME_W-2:0], 1'b0};
               if (bit_q == BIT_W'(FRAME_W - 1)) begin
                  bit_d   = '0;
                  state_d = S_TURN;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         S_TURN: begin
            div_d   = '0;
            bit_d   = '0;
            state_d = S_RX;
         end
         S_RX: begin
            // Sample on the edge closing the last sclk-high clock of the bit.
            if (div_q == DIV_W'(BIT_PERIOD - 2)) begin
               rx_d = {rx_q[RES_W-2:0], miso_i};
            end
            if (bit_end_c) begin
               div_d = '0;
               if (bit_q == BIT_W'(RES_W - 1)) begin
                  bit_d   = '0;
                  state_d = S_DONE;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (abort_c) begin
         state_d = S_IDLE;
         div_d   = '0;
         bit_d   = '0;
      end
   end

   // Outputs are computed from the upcoming state so the registers line up with it.
   always_comb begin
      nss_d    = 1'b1;
      sclk_d   = 1'b0;
      mosi_d   = 1'b0;
      done_d   = 1'b0;
      busy_d   = (state_d != S_IDLE);
      result_d = result_q;
      case (state_d)
         S_SETUP: begin
            nss_d  = 1'b0;
            mosi_d = tx_d[FRAME_W-1];
         end
         S_TX: begin
            nss_d  = 1'b0;
            mosi_d = tx_d[FRAME_W-1];
            sclk_d = (div_d == DIV_W'(BIT_PERIOD - 1));
         end
         S_TURN: begin
            nss_d  = 1'b0;
            sclk_d = 1'b1;
         end
         S_RX: begin
            nss_d  = 1'b0;
            sclk_d = (div_d != DIV_W'(BIT_PERIOD - 1));
         end
         S_DONE: begin
            done_d   = 1'b1;
            result_d = rx_d;
         end
         default: begin
         end
      endcase
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign result_o = result_q;
   assign sclk_o   = sclk_q;
   assign mosi_o   = mosi_q;
   assign nss_o    = nss_q;

endmodule

// File: tb/tb_spi_mul_master.sv
// Bench for spi_mul_master: slave model on the SPI side plus a cycle-timeline reference model.
// Abort scenario is exercised when SPI_MUL_MASTER_ABORT_EN is defined.
module tb_spi_mul_master;

   localparam int BP      = 4;
   localparam int SC      = 2;
   localparam int FW      = 68;
   localparam int K_TURN  = SC + FW * BP;
   localparam int K_RX0   = K_TURN + 1;
   localparam int K_DONE  = K_RX0 + 32 * BP;
   localparam int LIMIT   = 1000;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  op    = 4'h0;
   logic [31:0] a     = 32'h0;
   logic [31:0] b     = 32'h0;
   logic        abort = 1'b0;
   logic        miso  = 1'b0;
   logic        busy, done, sclk, mosi, nss;
   logic [31:0] result;
`ifdef SPI_MUL_MASTER_ABORT_EN
   logic        aborted;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic chk_en = 1'b0;

   spi_mul_master #(.BIT_PERIOD(BP), .SETUP_CYCLES(SC)) dut (
      .clock_i     (clk),
      .reset_i     (rst),
      .start_i     (start),
      .opcode_i    (op),
      .operand_a_i (a),
      .operand_b_i (b),
`ifdef SPI_MUL_MASTER_ABORT_EN
      .abort_i     (abort),
      .aborted_o   (aborted),
`endif
      .busy_o      (busy),
      .done_o      (done),
      .result_o    (result),
      .sclk_o      (sclk),
      .mosi_o      (mosi),
      .nss_o       (nss),
      .miso_i      (miso)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] slave_result(input logic [67:0] f);
      logic [31:0] x, y;
      x = f[63:32];
      y = f[31:0];
      return (f[67:64] == 4'b1001) ? x * y : 32'h0;
   endfunction

   // Slave model: samples mosi while sclk=1, computes on the turnaround clock, shifts miso while sclk=0.
   int          s_cnt   = 0;
   int          s_phase = 0;
   logic [67:0] s_rx    = '0;
   logic [67:0] s_frame = '0;
   logic [31:0] s_tx    = '0;
   always @(posedge clk) begin
      logic [31:0] r;
      if (nss) begin
         s_cnt   <= 0;
         s_phase <= 0;
         miso    <= 1'b0;
      end else begin
         case (s_phase)
            0: if (sclk) begin
               s_rx  <= {s_rx[66:0], mosi};
               s_cnt <= s_cnt + 1;
               if (s_cnt == FW - 1) s_phase <= 1;
            end
            1: if (sclk) begin
               r        = slave_result(s_rx);
               s_frame <= s_rx;
               s_tx    <= r;
               miso    <= r[31];
               s_phase <= 2;
            end
            2: if (!sclk) begin
               s_tx <= {s_tx[30:0], 1'b0};
               miso <= s_tx[30];
            end
            default: ;
         endcase
      end
   end

   // Reference model: transaction position counted in cycles since the start-sampling edge.
   logic        m_busy    = 1'b0;
   int          m_k       = 0;
   logic [67:0] m_frame   = '0;
   logic [31:0] m_held    = '0;
   logic        m_aborted = 1'b0;
   always @(posedge clk) begin
      m_aborted <= 1'b0;
      if (rst) begin
         if (!(m_busy && m_k < K_DONE)) m_held <= 32'h0;
         m_busy <= 1'b0;
         m_k    <= 0;
      end else if (m_busy && m_k < K_DONE && abort) begin
`ifdef SPI_MUL_MASTER_ABORT_EN
         m_busy    <= 1'b0;
         m_k       <= 0;
         m_aborted <= 1'b1;
`endif
      end else if (!m_busy) begin
         if (start) begin
            m_busy  <= 1'b1;
            m_k     <= 0;
            m_frame <= {op, a, b};
         end
      end else if (m_k == K_DONE) begin
         m_busy <= 1'b0;
         m_held <= slave_result(m_frame);
      end else begin
         m_k <= m_k + 1;
      end
   end

   // Per-cycle compare of every DUT output against the model.
   always @(negedge clk) begin
      logic        e_nss, e_sclk, e_mosi, e_busy, e_done;
      logic [31:0] e_res;
      int          t;
      if (chk_en) begin
         e_nss = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; e_done = 1'b0;
         if (m_busy) begin
            e_busy = 1'b1;
            e_done = (m_k == K_DONE);
            e_nss  = (m_k == K_DONE);
            if (m_k < SC) begin
               e_mosi = m_frame[FW-1];
            end else if (m_k < K_TURN) begin
               t      = m_k - SC;
               e_sclk = (t % BP == BP - 1);
               e_mosi = m_frame[FW - 1 - t / BP];
            end else if (m_k == K_TURN) begin
               e_sclk = 1'b1;
            end else if (m_k < K_DONE) begin
               e_sclk = ((m_k - K_RX0) % BP != BP - 1);
            end
         end
         e_res = (m_busy && m_k == K_DONE) ? slave_result(m_frame) : m_held;
         chk("nss",    68'(nss),    68'(e_nss));
         chk("sclk",   68'(sclk),   68'(e_sclk));
         chk("mosi",   68'(mosi),   68'(e_mosi));
         chk("busy",   68'(busy),   68'(e_busy));
         chk("done",   68'(done),   68'(e_done));
         chk("result", 68'(result), 68'(e_res));
`ifdef SPI_MUL_MASTER_ABORT_EN
         chk("aborted", 68'(aborted), 68'(m_aborted));
`endif
      end
   end

   // Called at the negedge of cycle 0; returns the cycle index of done and the result seen then.
   task automatic wait_done(output int cyc, output logic [31:0] res);
      cyc = 0;
      while (!done && cyc < LIMIT) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= LIMIT) chk("done_timeout", 68'(done), 68'(1));
      res = result;
   endtask

   // Called at an idle-cycle negedge; leaves the bench at the idle-cycle negedge after done.
   task automatic run_txn(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int cyc, output logic [31:0] res);
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc, res);
      @(negedge clk);
   endtask

   initial begin
      int          cyc;
      logic [31:0] res;
      int          ndone;

      @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_nss",    68'(nss),    68'(1));
      chk("rst_sclk",   68'(sclk),   68'(0));
      chk("rst_busy",   68'(busy),   68'(0));
      chk("rst_done",   68'(done),   68'(0));
      chk("rst_result", 68'(result), 68'(0));
      rst = 1'b0;
      @(negedge clk);

      run_txn(4'b1001, 32'd7, 32'd6, cyc, res);
      chk("mul_latency", 68'(cyc), 68'(403));
      chk("mul_7x6",     68'(res), 68'(32'h0000_002A));
      chk("mosi_frame",  s_frame,  68'h9_0000_0007_0000_0006);

      run_txn(4'b1001, 32'hFFFF_FFFF, 32'd2, cyc, res);
      chk("ovf_ffx2", 68'(res), 68'(32'hFFFF_FFFE));
      run_txn(4'b1001, 32'h0001_0000, 32'h0001_0000, cyc, res);
      chk("ovf_wrap", 68'(res), 68'(32'h0));

      run_txn(4'b0000, 32'd5, 32'd3, cyc, res);
      chk("nop_latency", 68'(cyc), 68'(403));
      chk("nop_result",  68'(res), 68'(32'h0));

      // start held through a whole frame, operand_a changed after acceptance
      op = 4'b1001; a = 32'd7; b = 32'd6; start = 1'b1;
      @(negedge clk);
      a = 32'd9;
      wait_done(cyc, res);
      chk("held_latency", 68'(cyc), 68'(403));
      chk("held_first",   68'(res), 68'(32'h0000_002A));
      chk("gap_done_nss", 68'(nss), 68'(1));
      @(negedge clk);
      chk("gap_idle_nss",  68'(nss),  68'(1));
      chk("gap_idle_busy", 68'(busy), 68'(0));
      @(negedge clk);
      start = 1'b0;
      chk("second_nss", 68'(nss), 68'(0));
      wait_done(cyc, res);
      chk("held_second", 68'(res), 68'(32'h0000_0036));
      @(negedge clk);

      // reset during TX bit 40 (cycles 162..165)
      op = 4'b1001; a = 32'd1; b = 32'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (163) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstmid_nss",    68'(nss),    68'(1));
      chk("rstmid_sclk",   68'(sclk),   68'(0));
      chk("rstmid_busy",   68'(busy),   68'(0));
      chk("rstmid_done",   68'(done),   68'(0));
      chk("rstmid_result", 68'(result), 68'(32'h0000_0036));
      @(negedge clk);
      run_txn(4'b1001, 32'd3, 32'd4, cyc, res);
      chk("after_rst_3x4", 68'(res), 68'(32'h0000_000C));

`ifdef SPI_MUL_MASTER_ABORT_EN
      // abort during RX bit 10 (cycles 315..318)
      op = 4'b1001; a = 32'h1234_5678; b = 32'h10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (316) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_nss",     68'(nss),     68'(1));
      chk("abort_sclk",    68'(sclk),    68'(0));
      chk("abort_pulse",   68'(aborted), 68'(1));
      chk("abort_done",    68'(done),    68'(0));
      chk("abort_result",  68'(result),  68'(32'h0000_000C));
      @(negedge clk);
      chk("abort_one_cyc", 68'(aborted), 68'(0));
      ndone = 0;
      repeat (150) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("abort_no_done", 68'(ndone), 68'(0));
      run_txn(4'b1001, 32'd5, 32'd5, cyc, res);
      chk("after_abort_5x5", 68'(res), 68'(32'h0000_0019));
`endif

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_mul_master.md
Name: spi_mul_master

Overview:
- SPI initiator that drives one multiplier transaction into the SPI multiplier slave and reads the 32-bit result back.
- Sits between the host-side control logic and the shared spi_if bus; the slave sits on the other side.
- Frame sent: 4-bit opcode, then 32-bit A, then 32-bit B, all MSB first. Frame received: 32-bit result, MSB first.
- Timing is matched to the slave: it samples mosi on any system clock where sclk=1, and shifts miso on any system clock where sclk=0 during its send phase.

Parameters:
- BIT_PERIOD, 4, system clocks per SPI bit; legal range 2..255.
- SETUP_CYCLES, 2, clocks nss is held low before the first sclk high; legal minimum 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a transaction; sampled only in IDLE.
- opcode  in  4  opcode to send (1001 = multiply); captured on accepted start.
- operand_a  in  32  operand A; captured on accepted start.
- operand_b  in  32  operand B; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until DONE inclusive.
- done  out  1  one-cycle pulse; result is valid in that cycle.
- result  out  32  last received result; held until the next done.
- spi_if  modport  -  spi_if.MASTER; drives sclk, mosi, nss; reads miso.

Behaviour:
- Reset (synchronous): state=IDLE, nss=1, sclk=0, mosi=0, busy=0, done=0, result=0, counters=0.
- Reset mid-transfer: nss=1 and sclk=0 from the next cycle. Any partial transaction is lost. result keeps its last value.
- IDLE:
  - Outputs: nss=1, sclk=0, mosi=0.
  - start=1 loads a 68-bit tx shift register with {opcode, operand_a, operand_b} and moves to SETUP.
  - start is ignored in every other state.
- SETUP:
  - nss=0, sclk=0, mosi=tx[67].
  - Lasts SETUP_CYCLES clocks, then moves to TX.
- TX (68 bits):
  - For each bit, mosi=tx[67] for BIT_PERIOD clocks.
  - sclk=0 for the first BIT_PERIOD-1 clocks and sclk=1 for exactly the last clock.
  - On the clock edge that ends the sclk-high clock: shift tx left by 1 and increment the bit counter.
  - After bit 67, go to TURN.
- TURN:
  - Exactly 1 clock with sclk=1, nss=0, mosi=0. This covers the slave's execute cycle.
  - Then go to RX.
- RX (32 bits):
  - For each bit: sclk=1 for BIT_PERIOD-1 clocks, then sclk=0 for exactly 1 clock. mosi=0 throughout.
  - miso is sampled on the edge that ends the last sclk-high clock: rx <= {rx[30:0], miso}.
  - The sclk-low clock lets the slave advance to its next bit.
  - After the 32nd low clock, go to DONE.
- DONE:
  - 1 clock: nss=1, sclk=0, done=1, result<=rx, busy=1.
  - Then IDLE. The earliest new start is accepted in the following IDLE cycle, so nss is high for at least 2 clocks between frames.
- Latency: cycle 0 is the first clock after the start-sampling edge. done is high in cycle SETUP_CYCLES + 1 + 100*BIT_PERIOD. With defaults that is cycle 403.
- Counters: bit counter is 7 bits (0..67); the divider counter is 8 bits. Both wrap to 0 at each bit or phase boundary, with no overflow.
- result holds only the 32 bits received. Truncation and opcode filtering are done by the slave.

Optional Feature:
- Macro: SPI_MUL_MASTER_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit) and output port aborted (1-cycle pulse).
  - abort=1 in SETUP, TX, TURN or RX: next cycle nss=1, sclk=0, mosi=0, aborted=1, done=0, result unchanged. Then IDLE.
  - abort is ignored in IDLE and DONE. abort beats start when both are asserted.
- Not defined: neither port exists and transactions always run to completion.

Test Plan:
- Directed multiply, using a slave model: opcode=1001, A=7, B=6 -> done at cycle 403 with defaults, result=0x0000002A. mosi bit sequence is 1001 then 0x00000007 then 0x00000006, MSB first.
- Overflow truncation: opcode=1001, A=0xFFFFFFFF, B=2 -> result=0xFFFFFFFE. A=0x00010000, B=0x00010000 -> result=0x00000000.
- Non-multiply opcode: opcode=0000, A=5, B=3 -> result=0x00000000. Frame timing is identical to the multiply case.
- start held high for the whole transaction with a different operand_a -> the second start is taken only in the IDLE cycle after done. The first result is unaffected, and nss stays high for at least 2 cycles between frames.
- reset pulsed during TX bit 40 -> the next cycle has nss=1, sclk=0, busy=0, done=0. A subsequent transaction with A=3, B=4 returns 0x0000000C.
- Compile with SPI_MUL_MASTER_ABORT_EN: abort during RX bit 10 -> the next cycle has nss=1 and aborted=1 for exactly one cycle, no done pulse, and result keeps its prior value.
